keypad_scanner_param: RTL and testbench

//  Parametrised matrix-keypad scanner with integrated press/release debounce.

---
 rtl/keypad_scanner_param.sv | 164 ++++++++++++++++
 tb/tb_keypad_scanner_param.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner_param.sv
// -----------------------------------------------------------------------------
// keypad_scanner_param
//   Scans a matrix keypad and debounces both the press and the release of a key.
//   Exactly one row is driven low at a time. The columns arrive already
//   synchronised and are active-high. An accepted key is reported as a linear
//   code (row*COLS + column index) together with a one-cycle valid strobe.
//   The block also keeps the code that was current before the latest accept.
//   A sample that shows more than one closed column is rejected and flagged.
//
// Ports
//   clk        in   1       system clock
//   reset      in   1       synchronous, active-high reset
//   col_sync   in   COLS    synchronised column inputs, 1 = key closed
//   r_sel      out  ROWS    row drive, active-low, exactly one bit low
//   key_code   out  CODE_W  latest accepted key code
//   prev_code  out  CODE_W  key_code value before the latest accept
//   key_valid  out  1       one-cycle pulse when key_code takes a new value
//   key_held   out  1       accepted key is down or its release is debouncing
//   multi_err  out  1       one-cycle pulse on a multi-column scan sample
// -----------------------------------------------------------------------------
module keypad_scanner_param #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SETTLE   = 2,
  parameter int DEBOUNCE = 31,
  localparam int CODE_W  = $clog2(ROWS * COLS),
  localparam int CNT_MAX = (SETTLE > DEBOUNCE) ? SETTLE : DEBOUNCE,
  localparam int CNT_W   = $clog2(CNT_MAX + 1),
  localparam int ROW_W   = $clog2(ROWS),
  localparam int COL_W   = $clog2(COLS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [COLS-1:0]   col_sync,
  output logic [ROWS-1:0]   r_sel,
  output logic [CODE_W-1:0] key_code,
  output logic [CODE_W-1:0] prev_code,
  output logic              key_valid,
  output logic              key_held,
  output logic              multi_err
);

  typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, REL_DB} state_t;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] DB_LIMIT    = CNT_W'(DEBOUNCE);

  state_t             state;
  logic [ROW_W-1:0]   row;
  logic [CNT_W-1:0]   cnt;      // settle count in SCAN, debounce count otherwise
  logic [COLS-1:0]    pattern;  // one-hot column pattern under press debounce
  logic [COL_W-1:0]   col_idx;  // bit index of pattern

  logic               col_zero;
  logic               col_onehot;
  logic [COL_W-1:0]   sample_idx;
  logic [ROW_W-1:0]   row_next;
  logic [CODE_W-1:0]  new_code;

  function automatic logic [ROWS-1:0] row_drive(input logic [ROW_W-1:0] r);
    return ~(ROWS'(1) << r);
  endfunction

  // NOTE: every variable assigned in always_comb gets a default value first,
  // so that no path through the block leaves it unassigned and infers a latch.
  always_comb begin
    col_zero   = (col_sync == '0);
    col_onehot = $onehot(col_sync);
    sample_idx = '0;
    for (int i = 0; i < COLS; i++) begin
      if (col_sync[i]) sample_idx = COL_W'(i);
    end
    row_next = (row == ROW_W'(ROWS - 1)) ? '0 : row + 1'b1;
    new_code = CODE_W'(row) * CODE_W'(COLS) + CODE_W'(col_idx);
  end

  // NOTE: state registers use non-blocking assignments, so every right-hand
  // side reads the value from before the clock edge (prev_code <= key_code
  // captures the old code while key_code is updated in the same edge).
  // NOTE: reset clears every register, including the pattern and index
  // latches. The debounce compares against pattern, so it needs a known value.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SCAN;
      row       <= '0;
      r_sel     <= row_drive('0);
      cnt       <= '0;
      pattern   <= '0;
      col_idx   <= '0;
      key_code  <= '0;
      prev_code <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      multi_err <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      multi_err <= 1'b0;
      case (state)
        SCAN: begin
          if (cnt == SETTLE_LAST) begin
            cnt <= '0;
            if (col_onehot) begin
              pattern <= col_sync;
              col_idx <= sample_idx;
              state   <= PRESS_DB;
              cnt     <= CNT_W'(1);  // the scan sample is the first match
            end else begin
              // Ghosting: several columns closed. Skip the row without accepting.
              if (!col_zero) multi_err <= 1'b1;
              row   <= row_next;
              r_sel <= row_drive(row_next);
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        PRESS_DB: begin
          if (col_sync != pattern) begin
            state <= SCAN;  // bounce: rescan the same row from a fresh settle
            cnt   <= '0;
          end else if (cnt == DB_LIMIT) begin
            key_code  <= new_code;
            prev_code <= key_code;
            key_valid <= 1'b1;
            key_held  <= 1'b1;
            state     <= HELD;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        HELD: begin
          if (col_zero) begin
            state <= REL_DB;
            cnt   <= CNT_W'(1);
          end
        end

        REL_DB: begin
          if (!col_zero) begin
            state <= HELD;  // release glitch: the key is still down
            cnt   <= '0;
          end else if (cnt == DB_LIMIT) begin
            state    <= SCAN;
            cnt      <= '0;
            key_held <= 1'b0;
            row      <= row_next;
            r_sel    <= row_drive(row_next);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= SCAN;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner_param.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner_param
//   Bench for two instances of keypad_scanner_param:
//   dut_a uses ROWS=4, COLS=4, SETTLE=2, DEBOUNCE=4.
//   dut_b uses ROWS=2, COLS=3, SETTLE=1, DEBOUNCE=1.
//   A behavioural model of each instance is compared with its outputs on
//   every clock cycle. Constant expectations are added for reset, the scan
//   order and the key scenarios.
// -----------------------------------------------------------------------------
module tb_keypad_scanner_param;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_a, reset_b;
  logic [3:0] col_a;
  logic [2:0] col_b;

  logic [3:0] r_sel_a, code_a, prev_a;
  logic       valid_a, held_a, merr_a;
  logic [1:0] r_sel_b;
  logic [2:0] code_b, prev_b;
  logic       valid_b, held_b, merr_b;

  keypad_scanner_param #(.ROWS(4), .COLS(4), .SETTLE(2), .DEBOUNCE(4)) dut_a (
    .clk(clk), .reset(reset_a), .col_sync(col_a), .r_sel(r_sel_a),
    .key_code(code_a), .prev_code(prev_a), .key_valid(valid_a),
    .key_held(held_a), .multi_err(merr_a)
  );

  keypad_scanner_param #(.ROWS(2), .COLS(3), .SETTLE(1), .DEBOUNCE(1)) dut_b (
    .clk(clk), .reset(reset_b), .col_sync(col_b), .r_sel(r_sel_b),
    .key_code(code_b), .prev_code(prev_b), .key_valid(valid_b),
    .key_held(held_b), .multi_err(merr_b)
  );

  // ---------------------------------------------------------------------------
  // Behavioural model. It is described in keypad terms: the row currently
  // scanned, how long that row has dwelt, whether a candidate key is being
  // confirmed, and whether an accepted key is down or being released.
  // ---------------------------------------------------------------------------
  typedef struct {
    int row, dwell, run, pat, code, prev;
    bit pressing, holding, releasing, valid, merr;
  } mdl_t;

  function automatic int ones(int v, int n);
    int k = 0;
    for (int i = 0; i < n; i++) k += (v >> i) & 1;
    return k;
  endfunction

  function automatic mdl_t mstep(mdl_t m, bit rst, int col, int rows, int cols,
                                 int settle, int deb);
    mdl_t n = m;
    n.valid = 0;
    n.merr  = 0;
    if (rst) begin
      n.row = 0; n.dwell = 0; n.run = 0; n.pat = 0; n.code = 0; n.prev = 0;
      n.pressing = 0; n.holding = 0; n.releasing = 0;
      return n;
    end
    if (m.pressing) begin
      if (col != m.pat) begin
        n.pressing = 0;
        n.dwell    = 0;
      end else if (m.run == deb) begin
        n.prev     = m.code;
        n.code     = m.row * cols + $clog2(m.pat);
        n.valid    = 1;
        n.pressing = 0;
        n.holding  = 1;
      end else begin
        n.run = m.run + 1;
      end
    end else if (m.holding) begin
      if (!m.releasing) begin
        if (col == 0) begin
          n.releasing = 1;
          n.run       = 1;
        end
      end else if (col != 0) begin
        n.releasing = 0;
      end else if (m.run == deb) begin
        n.holding   = 0;
        n.releasing = 0;
        n.row       = (m.row + 1) % rows;
        n.dwell     = 0;
      end else begin
        n.run = m.run + 1;
      end
    end else if (m.dwell < settle - 1) begin
      n.dwell = m.dwell + 1;
    end else begin
      n.dwell = 0;
      if (ones(col, cols) == 1) begin
        n.pressing = 1;
        n.pat      = col;
        n.run      = 1;
      end else begin
        n.merr = (col != 0);
        n.row  = (m.row + 1) % rows;
      end
    end
    return n;
  endfunction

  // ---------------------------------------------------------------------------
  // Checking infrastructure
  // ---------------------------------------------------------------------------
  int   total = 0;
  int   bad   = 0;
  int   nvalid_a = 0, nmerr_a = 0, nvalid_b = 0;
  mdl_t ma, mb;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply the current inputs for one clock, then compare both instances with
  // their models.
  task automatic tick();
    @(posedge clk);
    #1;
    ma = mstep(ma, reset_a, int'(col_a), 4, 4, 2, 4);
    mb = mstep(mb, reset_b, int'(col_b), 2, 3, 1, 1);
    check("a_rsel",  32'(r_sel_a), 32'((~(1 << ma.row)) & 15));
    check("a_code",  32'(code_a),  32'(ma.code));
    check("a_prev",  32'(prev_a),  32'(ma.prev));
    check("a_valid", 32'(valid_a), 32'(ma.valid));
    check("a_held",  32'(held_a),  32'(ma.holding));
    check("a_merr",  32'(merr_a),  32'(ma.merr));
    check("b_rsel",  32'(r_sel_b), 32'((~(1 << mb.row)) & 3));
    check("b_code",  32'(code_b),  32'(mb.code));
    check("b_prev",  32'(prev_b),  32'(mb.prev));
    check("b_valid", 32'(valid_b), 32'(mb.valid));
    check("b_held",  32'(held_b),  32'(mb.holding));
    check("b_merr",  32'(merr_b),  32'(mb.merr));
    if (valid_a === 1'b1) nvalid_a++;
    if (merr_a === 1'b1)  nmerr_a++;
    if (valid_b === 1'b1) nvalid_b++;
  endtask

  // Wait (bounded) until dut_a drives the target row.
  task automatic wait_a(input logic [3:0] target);
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (r_sel_a == target) found = 1;
    end
    check("wait_a_row", 32'(found), 32'd1);
  endtask

  task automatic wait_b(input logic [1:0] target);
    bit found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (r_sel_b == target) found = 1;
    end
    check("wait_b_row", 32'(found), 32'd1);
  endtask

  function automatic int rand_col(int cols);
    int r = $urandom_range(0, 9);
    int v;
    if (r < 4)      v = 0;
    else if (r < 8) v = 1 << $urandom_range(0, cols - 1);
    else if (r == 8) v = (1 << $urandom_range(0, cols - 1)) | 1 | 2;
    else            v = $urandom_range(0, (1 << cols) - 1);
    return v & ((1 << cols) - 1);
  endfunction

  // Reset and scan-order vectors for dut_a. Each entry applies one clock.
  typedef struct {
    logic       rst;
    logic [3:0] col;
    logic [3:0] rsel;
    logic [3:0] code;
    logic       valid;
    logic       held;
    logic       merr;
  } vec_t;

  vec_t tbl[14];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_a = 1'b1; reset_b = 1'b1; col_a = '0; col_b = '0;

    tbl[0]  = '{1'b1, 4'b0000, 4'b1110, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 4'b0000, 4'b1110, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 4'b0000, 4'b1110, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 4'b0000, 4'b1110, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 4'b0000, 4'b1101, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 4'b0000, 4'b1101, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 4'b0000, 4'b1011, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 4'b0000, 4'b1011, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 4'b0000, 4'b0111, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 4'b0000, 4'b0111, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 4'b0000, 4'b1110, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 4'b0000, 4'b1110, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 4'b0011, 4'b1101, 4'd0, 1'b0, 1'b0, 1'b1};  // ghosting
    tbl[13] = '{1'b0, 4'b0000, 4'b1101, 4'd0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 14; i++) begin
      reset_a = tbl[i].rst;
      col_a   = tbl[i].col;
      tick();
      check("tbl_rsel",  32'(r_sel_a), 32'(tbl[i].rsel));
      check("tbl_code",  32'(code_a),  32'(tbl[i].code));
      check("tbl_prev",  32'(prev_a),  32'd0);
      check("tbl_valid", 32'(valid_a), 32'(tbl[i].valid));
      check("tbl_held",  32'(held_a),  32'(tbl[i].held));
      check("tbl_merr",  32'(merr_a),  32'(tbl[i].merr));
    end
    reset_b = 1'b0;

    // Press row1 col2 and hold it for 20 cycles.
    wait_a(4'b1101);
    nvalid_a = 0;
    col_a = 4'b0100;
    repeat (20) tick();
    check("press6_valid_count", 32'(nvalid_a), 32'd1);
    check("press6_code",        32'(code_a),   32'd6);
    check("press6_prev",        32'(prev_a),   32'd0);
    check("press6_held",        32'(held_a),   32'd1);
    col_a = 4'b0000;
    repeat (4) tick();
    check("rel6_still_held", 32'(held_a), 32'd1);
    tick();
    check("rel6_released", 32'(held_a), 32'd0);

    // Press row3 col0.
    wait_a(4'b0111);
    col_a = 4'b0001;
    repeat (12) tick();
    check("press12_code", 32'(code_a), 32'd12);
    check("press12_prev", 32'(prev_a), 32'd6);
    col_a = 4'b0000;
    repeat (8) tick();
    check("rel12_held", 32'(held_a), 32'd0);

    // Bouncing contact: never stable long enough to accept.
    nvalid_a = 0;
    for (int i = 0; i < 10; i++) begin
      col_a = 4'b0010; repeat (2) tick();
      col_a = 4'b0000; repeat (2) tick();
    end
    check("bounce_no_valid", 32'(nvalid_a), 32'd0);
    check("bounce_code",     32'(code_a),   32'd12);

    // Release glitch on row0 col1: held stays high, no second accept.
    wait_a(4'b1110);
    nvalid_a = 0;
    col_a = 4'b0010;
    repeat (8) tick();
    col_a = 4'b0000; repeat (2) tick();
    col_a = 4'b0010; repeat (4) tick();
    check("glitch_held",        32'(held_a),   32'd1);
    check("glitch_valid_count", 32'(nvalid_a), 32'd1);
    check("glitch_code",        32'(code_a),   32'd1);
    check("glitch_prev",        32'(prev_a),   32'd12);
    col_a = 4'b0000;
    repeat (8) tick();
    check("glitch_released", 32'(held_a), 32'd0);

    // Reset while a key is held.
    wait_a(4'b1110);
    col_a = 4'b0100;
    repeat (8) tick();
    check("pre_reset_held", 32'(held_a), 32'd1);
    reset_a = 1'b1;
    tick();
    check("rst_held_rsel",  32'(r_sel_a), 32'b1110);
    check("rst_held_code",  32'(code_a),  32'd0);
    check("rst_held_prev",  32'(prev_a),  32'd0);
    check("rst_held_held",  32'(held_a),  32'd0);
    check("rst_held_valid", 32'(valid_a), 32'd0);
    col_a = 4'b0000;
    reset_a = 1'b0;

    // Reset during press debounce: the pending key is never accepted.
    wait_a(4'b1011);
    nvalid_a = 0;
    col_a = 4'b1000;
    repeat (2) tick();
    reset_a = 1'b1;
    tick();
    check("rst_pdb_rsel",  32'(r_sel_a),  32'b1110);
    check("rst_pdb_code",  32'(code_a),   32'd0);
    check("rst_pdb_held",  32'(held_a),   32'd0);
    check("rst_pdb_valid", 32'(nvalid_a), 32'd0);
    col_a = 4'b0000;
    reset_a = 1'b0;
    repeat (4) tick();

    // 2x3 instance with SETTLE=1, DEBOUNCE=1: row1 col2 gives code 5.
    wait_b(2'b01);
    nvalid_b = 0;
    col_b = 3'b100;
    repeat (3) tick();
    check("b_code5",        32'(code_b),   32'd5);
    check("b_prev0",        32'(prev_b),   32'd0);
    check("b_valid_count",  32'(nvalid_b), 32'd1);
    check("b_held_on",      32'(held_b),   32'd1);
    col_b = 3'b000;
    repeat (3) tick();
    check("b_held_off", 32'(held_b), 32'd0);

    // Randomised bursts on both instances, with occasional resets.
    for (int b = 0; b < 300; b++) begin
      int len = $urandom_range(1, 12);
      col_a = 4'(rand_col(4));
      col_b = 3'(rand_col(3));
      reset_a = ($urandom_range(0, 39) == 0);
      reset_b = ($urandom_range(0, 39) == 0);
      if (reset_a || reset_b) begin
        tick();
        reset_a = 1'b0;
        reset_b = 1'b0;
      end
      repeat (len) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
